// File: rtl/calc_pkg.sv
// Shared sizing and FSM encoding for the push/add calculator.
package calc_pkg;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_TWO  = (PTR_W + 1)'(2);

    typedef enum logic [1:0] {
        IDLE,
        POP_A,
        POP_B,
        WRITE
    } state_t;
endpackage

// File: rtl/calc_if.sv
// Board-facing signal bundle for the calculator: switches, buttons, mode, display and flags.
interface calc_if;
    import calc_pkg::*;

    logic             stackQueue;
    logic [WIDTH-1:0] switches;
    logic [4:0]       btns;
    logic [31:0]      toSSEG;
    logic             empty;
    logic             full;

    modport master (output stackQueue, switches, btns, input toSSEG, empty, full);
    modport slave  (input stackQueue, switches, btns, output toSSEG, empty, full);
endinterface

// File: rtl/sq_buffer.sv
// 32-entry buffer acting as a LIFO or a wrapping FIFO; one write and one read port.
module sq_buffer
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_mode,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [PTR_W:0]   o_count,
    output logic             o_empty,
    output logic             o_full
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_top;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic             r_empty;
    logic             r_full;

    logic [PTR_W:0]   w_top_m1;
    logic [PTR_W-1:0] w_waddr;
    logic [PTR_W-1:0] w_raddr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_top_m1  = r_top - 1'b1;
    // Read port always presents the entry the next pop would remove.
    assign w_waddr   = i_mode ? r_tail : r_top[PTR_W-1:0];
    assign w_raddr   = i_mode ? r_head : w_top_m1[PTR_W-1:0];
    assign w_push_ok = i_push && !i_flush && (r_count != CNT_FULL);
    assign w_pop_ok  = i_pop && !i_flush && (r_count != '0);

    assign o_rdata = r_mem[w_raddr];
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_top   <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            r_empty <= (r_count == '0);
            r_full  <= (r_count == CNT_FULL);
            if (i_flush) begin
                r_top   <= '0;
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else if (w_push_ok) begin
                r_count <= r_count + 1'b1;
                if (i_mode) begin
                    r_tail <= r_tail + 1'b1;
                end else begin
                    r_top <= r_top + 1'b1;
                end
            end else if (w_pop_ok) begin
                r_count <= r_count - 1'b1;
                if (i_mode) begin
                    r_head <= r_head + 1'b1;
                end else begin
                    r_top <= w_top_m1;
                end
            end
        end
    end
endmodule

// File: rtl/top_level.sv
// 16-bit push/add calculator: button edge detect, add sequencer, display register.
module top_level
    import calc_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    calc_if.slave bus
);
    logic [1:0]       r_btn_q;
    logic             r_sq_sync;
    logic             r_mode;
    logic [WIDTH-1:0] r_disp;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    state_t           r_state;

    state_t           w_next;
    logic             w_push_edge;
    logic             w_add_edge;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic             w_load_a;
    logic             w_load_b;
    logic             w_disp_ld;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_rdata;
    logic [PTR_W:0]   w_count;
    logic             w_unused_btns;

    assign w_push_edge   = bus.btns[0] & ~r_btn_q[0];
    assign w_add_edge    = bus.btns[1] & ~r_btn_q[1];
    assign w_sum         = r_a + r_b;
    assign w_unused_btns = ^bus.btns[4:2];
    assign bus.toSSEG    = {{(32 - WIDTH){1'b0}}, r_disp};

    sq_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_mode  (r_mode),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_empty (bus.empty),
        .o_full  (bus.full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_q   <= '0;
            r_sq_sync <= 1'b0;
            r_mode    <= 1'b0;
            r_disp    <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_state   <= IDLE;
        end else begin
            r_btn_q   <= bus.btns[1:0];
            r_sq_sync <= bus.stackQueue;
            r_state   <= w_next;
            if (w_flush)   r_mode <= r_sq_sync;
            if (w_load_a)  r_a    <= w_rdata;
            if (w_load_b)  r_b    <= w_rdata;
            if (w_disp_ld) r_disp <= w_wdata;
        end
    end

    // Mode change outranks buttons; a push edge suppresses a simultaneous add edge.
    always_comb begin
        w_next    = r_state;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_flush   = 1'b0;
        w_load_a  = 1'b0;
        w_load_b  = 1'b0;
        w_disp_ld = 1'b0;
        w_wdata   = bus.switches;
        case (r_state)
            IDLE: begin
                if (r_sq_sync != r_mode) begin
                    w_flush = 1'b1;
                end else if (w_push_edge) begin
                    if (w_count != CNT_FULL) begin
                        w_push    = 1'b1;
                        w_disp_ld = 1'b1;
                    end
                end else if (w_add_edge && (w_count >= CNT_TWO)) begin
                    w_next = POP_A;
                end
            end
            POP_A: begin
                w_pop    = 1'b1;
                w_load_a = 1'b1;
                w_next   = POP_B;
            end
            POP_B: begin
                w_pop    = 1'b1;
                w_load_b = 1'b1;
                w_next   = WRITE;
            end
            WRITE: begin
                w_push    = 1'b1;
                w_wdata   = w_sum;
                w_disp_ld = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for the push/add calculator in stack and queue modes.
module tb_top_level;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    calc_if bus ();

    top_level dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input int b, input int hold, input logic [15:0] sw);
        bus.switches = sw;
        bus.btns[b]  = 1'b1;
        repeat (hold) @(negedge clk);
        bus.btns = '0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic mode);
        @(negedge clk);
        rst            = 1'b0;
        bus.btns       = '0;
        bus.stackQueue = mode;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int exp_v;
        int q[$];
        int a;
        int b;
        n_cmp          = 0;
        n_bad          = 0;
        rst            = 1'b0;
        bus.btns       = '0;
        bus.switches   = '0;
        bus.stackQueue = 1'b0;
        repeat (2) @(negedge clk);

        // 1. reset state
        check("rst_sseg",  bus.toSSEG, 32'd0);
        check("rst_empty", {31'd0, bus.empty}, 32'd1);
        check("rst_full",  {31'd0, bus.full}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 2. stack fill
        for (int i = 1; i <= 32; i++) begin
            press(0, 2, 16'(i));
            check($sformatf("stk_push%0d", i), bus.toSSEG, 32'(i));
            if (i == 1)  check("stk_not_empty", {31'd0, bus.empty}, 32'd0);
            if (i == 31) check("stk_full31", {31'd0, bus.full}, 32'd0);
        end
        check("stk_full32", {31'd0, bus.full}, 32'd1);
        press(0, 2, 16'd99);
        check("stk_push33_disp", bus.toSSEG, 32'd32);
        check("stk_push33_full", {31'd0, bus.full}, 32'd1);

        // 3. stack add
        for (int k = 1; k <= 31; k++) begin
            press(1, 6, 16'd0);
            exp_v = 528 - ((31 - k) * (32 - k)) / 2;
            check($sformatf("stk_add%0d", k), bus.toSSEG, 32'(exp_v));
        end
        check("stk_add_notfull", {31'd0, bus.full}, 32'd0);
        press(1, 6, 16'd0);
        check("stk_add_ignored", bus.toSSEG, 32'd528);
        check("stk_one_left", {31'd0, bus.empty}, 32'd0);

        // 4. queue fill
        do_reset(1'b1);
        check("q_rst_sseg", bus.toSSEG, 32'd0);
        for (int i = 1; i <= 32; i++) begin
            press(0, 2, 16'(i));
            q.push_back(i);
        end
        check("q_full", {31'd0, bus.full}, 32'd1);
        check("q_fill_disp", bus.toSSEG, 32'd32);

        // 5. queue add, expected sums from a FIFO reference
        for (int k = 1; k <= 31; k++) begin
            press(1, 6, 16'd0);
            a = q.pop_front();
            b = q.pop_front();
            q.push_back((a + b) & 16'hFFFF);
            check($sformatf("q_add%0d", k), bus.toSSEG, 32'(q[$]));
        end
        check("q_final", bus.toSSEG, 32'd528);
        press(1, 6, 16'd0);
        check("q_add_ignored", bus.toSSEG, 32'd528);

        // mode change flushes, display kept
        bus.stackQueue = 1'b0;
        repeat (4) @(negedge clk);
        check("mode_flush_empty", {31'd0, bus.empty}, 32'd1);
        check("mode_flush_disp", bus.toSSEG, 32'd528);

        // 6. corner cases
        press(1, 6, 16'd0);
        check("add_empty_disp", bus.toSSEG, 32'd528);
        check("add_empty_flag", {31'd0, bus.empty}, 32'd1);
        press(0, 2, 16'd4);
        check("c_push4", bus.toSSEG, 32'd4);
        bus.switches = 16'd9;
        bus.btns[1:0] = 2'b11;
        repeat (2) @(negedge clk);
        bus.btns = '0;
        repeat (6) @(negedge clk);
        check("both_btns", bus.toSSEG, 32'd9);
        press(0, 10, 16'd5);
        check("held_push", bus.toSSEG, 32'd5);
        press(1, 6, 16'd0);
        check("c_add_9_5", bus.toSSEG, 32'd14);
        press(1, 6, 16'd0);
        check("c_add_4_14", bus.toSSEG, 32'd18);
        press(1, 6, 16'd0);
        check("c_add_single", bus.toSSEG, 32'd18);
        press(0, 2, 16'hFFFF);
        press(0, 2, 16'd2);
        press(1, 6, 16'd0);
        check("add_wrap16", bus.toSSEG, 32'd1);

        // reset asserted while the sequencer sits in POP_B
        press(0, 2, 16'd7);
        bus.btns[1] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midadd_empty", {31'd0, bus.empty}, 32'd1);
        check("midadd_sseg", bus.toSSEG, 32'd0);
        @(negedge clk);
        bus.btns = '0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        press(0, 2, 16'd6);
        check("post_rst_push", bus.toSSEG, 32'd6);
        press(1, 6, 16'd0);
        check("post_rst_add_ignored", bus.toSSEG, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
